// File: rtl/target_hit_scorer.sv
// Target hit detector and two-digit BCD score keeper for the snake game.
// Pulses target_reached once per hit, then locks out until the target moves or a timeout expires.
module target_hit_scorer #(
    parameter int GRID_X_MAX  = 159,
    parameter int GRID_Y_MAX  = 119,
    parameter int WIN_SCORE   = 10,
    parameter int LOCK_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_active,
    input  logic       head_valid,
    input  logic [7:0] head_x,
    input  logic [6:0] head_y,
    input  logic [7:0] target_addr_x,
    input  logic [6:0] target_addr_y,
    output logic       target_reached,
    output logic [3:0] score_units,
    output logic [3:0] score_tens,
    output logic       win
);

    localparam int              CW        = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CW-1:0]   LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [7:0]      X_MAX     = 8'(GRID_X_MAX);
    localparam logic [6:0]      Y_MAX     = 7'(GRID_Y_MAX);
    localparam logic [6:0]      WIN_BIN   = 7'(WIN_SCORE);

    typedef enum logic [1:0] {IDLE, ARMED, LOCKOUT, WON} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    units_reg, units_next;
    logic [3:0]    tens_reg, tens_next;
    logic          pulse_reg, pulse_next;
    logic          win_reg, win_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [7:0]    lat_x_reg, lat_x_next;
    logic [6:0]    lat_y_reg, lat_y_next;

    logic          hit;
    logic          target_moved;
    logic [3:0]    inc_units, inc_tens;
    logic [6:0]    inc_bin;

    assign hit = head_valid
              && (head_x == target_addr_x) && (head_y == target_addr_y)
              && (head_x <= X_MAX) && (head_y <= Y_MAX);

    assign target_moved = (target_addr_x != lat_x_reg) || (target_addr_y != lat_y_reg);

    // BCD increment that saturates at 99.
    always_comb begin
        inc_units = units_reg;
        inc_tens  = tens_reg;
        if (units_reg == 4'd9 && tens_reg == 4'd9) begin
            inc_units = units_reg;
        end else if (units_reg == 4'd9) begin
            inc_units = 4'd0;
            inc_tens  = tens_reg + 4'd1;
        end else begin
            inc_units = units_reg + 4'd1;
        end
        inc_bin = 7'(inc_tens) * 7'd10 + 7'(inc_units);
    end

    always_comb begin
        state_next = state_reg;
        units_next = units_reg;
        tens_next  = tens_reg;
        pulse_next = 1'b0;
        win_next   = win_reg;
        cnt_next   = cnt_reg;
        lat_x_next = lat_x_reg;
        lat_y_next = lat_y_reg;
        case (state_reg)
            IDLE: begin
                if (game_active) begin
                    state_next = ARMED;
                    units_next = 4'd0;
                    tens_next  = 4'd0;
                end
            end
            ARMED: begin
                if (!game_active) begin
                    state_next = IDLE;
                    win_next   = 1'b0;
                end else if (hit) begin
                    pulse_next = 1'b1;
                    units_next = inc_units;
                    tens_next  = inc_tens;
                    lat_x_next = target_addr_x;
                    lat_y_next = target_addr_y;
                    cnt_next   = '0;
                    if (inc_bin == WIN_BIN) begin
                        state_next = WON;
                        win_next   = 1'b1;
                    end else begin
                        state_next = LOCKOUT;
                    end
                end
            end
            LOCKOUT: begin
                if (!game_active) begin
                    state_next = IDLE;
                    win_next   = 1'b0;
                end else if (target_moved || cnt_reg == LOCK_LAST) begin
                    state_next = ARMED;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            WON: begin
                if (!game_active) begin
                    state_next = IDLE;
                    win_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            units_reg <= 4'd0;
            tens_reg  <= 4'd0;
            pulse_reg <= 1'b0;
            win_reg   <= 1'b0;
            cnt_reg   <= '0;
            lat_x_reg <= 8'd0;
            lat_y_reg <= 7'd0;
        end else begin
            state_reg <= state_next;
            units_reg <= units_next;
            tens_reg  <= tens_next;
            pulse_reg <= pulse_next;
            win_reg   <= win_next;
            cnt_reg   <= cnt_next;
            lat_x_reg <= lat_x_next;
            lat_y_reg <= lat_y_next;
        end
    end

    assign target_reached = pulse_reg;
    assign score_units    = units_reg;
    assign score_tens     = tens_reg;
    assign win            = win_reg;

endmodule
